// File: rtl/fp_pkg.sv
// Shared fp16 definitions for the unpacker front end and its optional
// class decoder: field positions, unpacker states and class codes.
package fp_pkg;

    localparam int unsigned FP16_W        = 16;
    localparam int unsigned FP16_SIGN_BIT = 15;
    localparam int unsigned FP16_EXP_MSB  = 14;
    localparam int unsigned FP16_EXP_LSB  = 10;
    localparam int unsigned FP16_EXP_W    = 5;
    localparam int unsigned FP16_MANT_MSB = 9;
    localparam int unsigned FP16_MANT_LSB = 0;
    localparam int unsigned FP16_MANT_W   = 10;

    // Which half of the held word is being presented downstream.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } unpack_state_e;

    typedef enum logic [2:0] {
        CLASS_ZERO      = 3'd0,
        CLASS_SUBNORMAL = 3'd1,
        CLASS_NORMAL    = 3'd2,
        CLASS_INF       = 3'd3,
        CLASS_NAN       = 3'd4
    } fp16_class_e;

    function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [FP16_W-1:0] v);
        return v[FP16_EXP_MSB:FP16_EXP_LSB];
    endfunction

    function automatic logic [FP16_MANT_W-1:0] fp16_mant(input logic [FP16_W-1:0] v);
        return v[FP16_MANT_MSB:FP16_MANT_LSB];
    endfunction

endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 class decode (zero/subnormal/normal/inf/NaN).
// Output forced to zero-class code when the operand is not valid.
module fp16_classify
    import fp_pkg::*;
(
    input  logic        valid_i,
    input  logic [15:0] fp16_i,
    output logic [2:0]  class_o
);

    logic [FP16_EXP_W-1:0]  exp_f;
    logic [FP16_MANT_W-1:0] mant_f;

    assign exp_f  = fp16_exp(fp16_i);
    assign mant_f = fp16_mant(fp16_i);

    // Decode exponent/mantissa extremes into a class code.
    always_comb begin
        class_o = CLASS_ZERO;
        if (valid_i) begin
            if (exp_f == '0) begin
                class_o = (mant_f == '0) ? CLASS_ZERO : CLASS_SUBNORMAL;
            end else if (exp_f == '1) begin
                class_o = (mant_f == '0) ? CLASS_INF : CLASS_NAN;
            end else begin
                class_o = CLASS_NORMAL;
            end
        end
    end

endmodule

// File: rtl/fp16_unpacker.sv
// Splits 32-bit words holding two packed fp16 values into a registered
// one-value-per-cycle valid/ready stream. A new word can be taken on the
// final beat of the current one, so there are no bubbles between words.
// Optional feature macro: FP16_CLASSIFY_EN adds out_class[2:0].
module fp16_unpacker
    import fp_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_single,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_fp16,
    output logic        out_last,
`ifdef FP16_CLASSIFY_EN
    output logic [2:0]  out_class,
`endif
    output logic [15:0] half_cnt
);

    unpack_state_e state_q;
    logic [31:0]   word_q;
    logic          single_q;
    logic          last_q;
    logic [15:0]   half_cnt_q;
    logic [15:0]   half_cnt_d;

    logic [15:0]   first_half;
    logic [15:0]   second_half;
    logic          final_beat;
    logic          out_hs;
    logic          accept;

    assign first_half  = LOW_FIRST ? word_q[15:0]  : word_q[31:16];
    assign second_half = LOW_FIRST ? word_q[31:16] : word_q[15:0];

    assign final_beat = (state_q == SECOND) || ((state_q == FIRST) && single_q);
    assign out_valid  = (state_q != EMPTY);
    assign out_hs     = out_valid && out_ready;
    assign in_ready   = (state_q == EMPTY) || (final_beat && out_ready);
    assign accept     = in_valid && in_ready;

    assign out_fp16   = (state_q == SECOND) ? second_half : first_half;
    assign out_last   = last_q && final_beat;
    assign half_cnt_d = half_cnt_q + 16'd1;
    assign half_cnt   = half_cnt_q;

    // Word capture, half sequencing and emitted-value counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            word_q     <= '0;
            single_q   <= 1'b0;
            last_q     <= 1'b0;
            half_cnt_q <= '0;
        end else begin
            if (out_hs) begin
                half_cnt_q <= half_cnt_d;
            end
            // Accept can only happen when empty or on a final-beat handshake,
            // so it always starts a fresh word.
            if (accept) begin
                word_q   <= in_data;
                single_q <= in_single;
                last_q   <= in_last;
                state_q  <= FIRST;
            end else if (out_hs) begin
                state_q <= final_beat ? EMPTY : SECOND;
            end
        end
    end

`ifdef FP16_CLASSIFY_EN
    fp16_classify u_classify (
        .valid_i (out_valid),
        .fp16_i  (out_fp16),
        .class_o (out_class)
    );
`endif

endmodule

// File: tb/tb_fp16_unpacker.sv
// Bench for fp16_unpacker: two instances (low-first and high-first) share
// one stimulus stream and are compared against a queue-based model.
module tb_fp16_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_single;
    logic        in_last;
    logic        out_ready;

    logic        lo_in_ready, lo_out_valid, lo_out_last;
    logic [15:0] lo_out_fp16, lo_half_cnt;
    logic        hi_in_ready, hi_out_valid, hi_out_last;
    logic [15:0] hi_out_fp16, hi_half_cnt;
`ifdef FP16_CLASSIFY_EN
    logic [2:0]  lo_class, hi_class;
`endif

    fp16_unpacker #(.LOW_FIRST(1'b1)) u_lo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (lo_in_ready),
        .in_data   (in_data),
        .in_single (in_single),
        .in_last   (in_last),
        .out_valid (lo_out_valid),
        .out_ready (out_ready),
        .out_fp16  (lo_out_fp16),
        .out_last  (lo_out_last),
`ifdef FP16_CLASSIFY_EN
        .out_class (lo_class),
`endif
        .half_cnt  (lo_half_cnt)
    );

    fp16_unpacker #(.LOW_FIRST(1'b0)) u_hi (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (hi_in_ready),
        .in_data   (in_data),
        .in_single (in_single),
        .in_last   (in_last),
        .out_valid (hi_out_valid),
        .out_ready (out_ready),
        .out_fp16  (hi_out_fp16),
        .out_last  (hi_out_last),
`ifdef FP16_CLASSIFY_EN
        .out_class (hi_class),
`endif
        .half_cnt  (hi_half_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: values still owed downstream for the current word, in order.
    logic [15:0] exp_lo[$];
    logic [15:0] exp_hi[$];
    bit          exp_last[$];
    logic [15:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [15:0] v);
        int unsigned e;
        int unsigned m;
        e = (int'(v) / 1024) % 32;
        m = int'(v) % 1024;
        if (e == 0)  return (m == 0) ? 3'd0 : 3'd1;
        if (e == 31) return (m == 0) ? 3'd3 : 3'd4;
        return 3'd2;
    endfunction

    function automatic bit model_ready();
        return (exp_lo.size() == 0) || (exp_lo.size() == 1 && out_ready);
    endfunction

    task automatic check_outputs();
        bit v;
        v = (exp_lo.size() != 0);
        check("lo_out_valid", lo_out_valid, v);
        check("hi_out_valid", hi_out_valid, v);
        check("lo_in_ready", lo_in_ready, model_ready());
        check("hi_in_ready", hi_in_ready, model_ready());
        check("lo_half_cnt", lo_half_cnt, exp_cnt);
        check("hi_half_cnt", hi_half_cnt, exp_cnt);
        if (v) begin
            check("lo_out_fp16", lo_out_fp16, exp_lo[0]);
            check("hi_out_fp16", hi_out_fp16, exp_hi[0]);
            check("lo_out_last", lo_out_last, exp_last[0]);
            check("hi_out_last", hi_out_last, exp_last[0]);
        end else begin
            check("lo_out_last_idle", lo_out_last, 1'b0);
            check("hi_out_last_idle", hi_out_last, 1'b0);
        end
`ifdef FP16_CLASSIFY_EN
        check("lo_out_class", lo_class, v ? ref_class(exp_lo[0]) : 3'd0);
        check("hi_out_class", hi_class, v ? ref_class(exp_hi[0]) : 3'd0);
`endif
    endtask

    // One clock: check at negedge, advance the model at posedge.
    task automatic cycle(output bit accepted);
        bit hs;
        @(negedge clk);
        check_outputs();
        accepted = in_valid && model_ready();
        hs       = (exp_lo.size() != 0) && out_ready;
        @(posedge clk);
        if (hs) begin
            void'(exp_lo.pop_front());
            void'(exp_hi.pop_front());
            void'(exp_last.pop_front());
            exp_cnt = exp_cnt + 16'd1;
        end
        if (accepted) begin
            if (in_single) begin
                exp_lo.push_back(in_data[15:0]);
                exp_hi.push_back(in_data[31:16]);
                exp_last.push_back(in_last);
            end else begin
                exp_lo.push_back(in_data[15:0]);
                exp_lo.push_back(in_data[31:16]);
                exp_hi.push_back(in_data[31:16]);
                exp_hi.push_back(in_data[15:0]);
                exp_last.push_back(1'b0);
                exp_last.push_back(in_last);
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit s, input bit l);
        in_valid  = v;
        in_data   = d;
        in_single = s;
        in_last   = l;
    endtask

    initial begin
        bit acc;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state.
        #2;
        check("rst_out_valid", lo_out_valid, 1'b0);
        check("rst_out_fp16_lo", lo_out_fp16, 16'h0000);
        check("rst_out_fp16_hi", hi_out_fp16, 16'h0000);
        check("rst_in_ready", lo_in_ready, 1'b1);
        check("rst_out_last", lo_out_last, 1'b0);
        check("rst_half_cnt", lo_half_cnt, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-value word, not last.
        drive(1'b1, 32'hC680_4380, 1'b0, 1'b0);
        cycle(acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) cycle(acc);

        // Same word ending a packet.
        drive(1'b1, 32'hC680_4380, 1'b0, 1'b1);
        cycle(acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) cycle(acc);

        // Back-pressure on a loaded word, with another word waiting upstream.
        out_ready = 1'b0;
        drive(1'b1, 32'hC680_4380, 1'b0, 1'b0);
        cycle(acc);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b1);
        repeat (5) cycle(acc);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(acc);
            if (acc) drive(1'b0, 32'h0, 1'b0, 1'b0);
        end

        // Back-to-back single-value words.
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        cycle(acc);
        drive(1'b1, 32'h0000_4380, 1'b1, 1'b0);
        cycle(acc);
        drive(1'b1, 32'h0000_C680, 1'b1, 1'b1);
        cycle(acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cycle(acc);

        // Class-interesting values.
        drive(1'b1, 32'h7C00_0001, 1'b0, 1'b0);
        cycle(acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(acc);
        drive(1'b1, 32'h7E00_0000, 1'b0, 1'b1);
        cycle(acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) cycle(acc);

        // Asynchronous reset while on the second half.
        drive(1'b1, 32'hC680_4380, 1'b0, 1'b0);
        cycle(acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(acc);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", lo_out_valid, 1'b0);
        check("arst_half_cnt", lo_half_cnt, 16'h0000);
        check("arst_in_ready", hi_in_ready, 1'b1);
        exp_lo.delete();
        exp_hi.delete();
        exp_last.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle(acc);

        // Random traffic; upstream holds a word until it is taken.
        acc = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (3) cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
